// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM encoding, fill byte
// and the auto-burst length helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    STORE
  } state_t;

  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam int AUTO_W = 11;

  // A zero length request means a full 1024-byte burst.
  function automatic logic [AUTO_W-1:0] auto_load(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/spi_fifo.sv
// First-word-fall-through byte FIFO with synchronous clear and occupancy count.
module spi_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Overflowing pushes and underflowing pops are silently dropped.
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Present zero when empty so the head reads 0x00 out of reset.
  assign dout = (count == '0) ? '0 : mem[rptr];

endmodule

// File: rtl/spi_xfer_seq.sv
// Byte sequencer feeding a byte-level SPI controller from a TX FIFO or an
// auto 0xFF fill burst, collecting received bytes into an RX FIFO.
module spi_xfer_seq
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       tx_full,
  input  logic [9:0] auto_len,
  input  logic       auto_start,
  input  logic       flush,
  output logic       busy,
  output logic       ovf,
  output logic [7:0] ctl_txdata,
  output logic       ctl_txstart,
  input  logic [7:0] ctl_rxdata,
  input  logic       ctl_busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t            state;
  logic [AUTO_W-1:0] auto_cnt;
  logic              issue_auto;
  logic              discard;

  logic [7:0]        tx_head;
  logic [CW-1:0]     tx_count;
  logic [CW-1:0]     rx_count;
  logic              tx_empty;
  logic              rx_full;
  logic              tx_pop;
  logic              rx_push;
  logic              have_src;
  logic              start_xfer;

  assign tx_empty   = (tx_count == '0);
  assign tx_full    = (tx_count == FULL_CNT);
  assign rx_full    = (rx_count == FULL_CNT);
  assign rx_valid   = (rx_count != '0);
  assign busy       = (state != IDLE) || !tx_empty;

  assign tx_pop     = (state == ISSUE) && !issue_auto;
  assign rx_push    = (state == STORE) && !discard;
  assign have_src   = (auto_cnt != '0) || !tx_empty;
  // A flush in the same cycle would clear the byte we are about to send.
  assign start_xfer = (state == IDLE) && have_src && !rx_full && !flush;

  spi_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .count (tx_count)
  );

  spi_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (rx_push),
    .din   (ctl_rxdata),
    .pop   (rd_en),
    .dout  (rd_data),
    .count (rx_count)
  );

  // Transfer FSM; a flush while a byte is in flight lets it finish but drops its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ctl_txstart <= 1'b0;
      ctl_txdata  <= 8'h00;
      issue_auto  <= 1'b0;
      discard     <= 1'b0;
    end else begin
      ctl_txstart <= 1'b0;
      case (state)
        IDLE: begin
          if (start_xfer) begin
            state       <= ISSUE;
            ctl_txstart <= 1'b1;
            issue_auto  <= (auto_cnt != '0);
            ctl_txdata  <= (auto_cnt != '0) ? FILL_BYTE : tx_head;
            discard     <= 1'b0;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
          if (flush) discard <= 1'b1;
        end
        WAIT_ACK: begin
          if (flush)    discard <= 1'b1;
          if (ctl_busy) state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (flush)     discard <= 1'b1;
          if (!ctl_busy) state   <= STORE;
        end
        STORE: begin
          state   <= IDLE;
          discard <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // New bursts are only accepted once the previous one has fully issued.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      auto_cnt <= '0;
    end else if ((state == ISSUE) && issue_auto) begin
      auto_cnt <= auto_cnt - 11'd1;
    end else if (auto_start && (auto_cnt == '0)) begin
      auto_cnt <= auto_load(auto_len);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ovf <= 1'b0;
    end else if (wr_en && tx_full) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Scoreboard bench for spi_xfer_seq with a behavioural spictrl responder.
module tb_spi_xfer_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       tx_full;
  logic [9:0] auto_len = 10'd0;
  logic       auto_start = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  logic       ovf;
  logic [7:0] ctl_txdata;
  logic       ctl_txstart;
  logic [7:0] ctl_rxdata = 8'h00;
  logic       ctl_busy = 1'b0;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int         txstart_cnt = 0;
  int         xfer_idx = 0;
  int         drop_idx = -1;
  bit         miso_ones = 1'b0;
  bit         rd_auto = 1'b0;
  logic [7:0] last_tx = 8'h00;

  spi_xfer_seq #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rx_valid    (rx_valid),
    .tx_full     (tx_full),
    .auto_len    (auto_len),
    .auto_start  (auto_start),
    .flush       (flush),
    .busy        (busy),
    .ovf         (ovf),
    .ctl_txdata  (ctl_txdata),
    .ctl_txstart (ctl_txstart),
    .ctl_rxdata  (ctl_rxdata),
    .ctl_busy    (ctl_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs; accepted writes go straight into the expected TX order.
  task automatic applyStimulus(input logic we, input logic [7:0] d, input logic rd,
                               input logic as, input logic [9:0] len, input logic fl);
    wr_en      = we;
    wr_data    = d;
    rd_en      = rd;
    auto_start = as;
    auto_len   = len;
    flush      = fl;
    if (we && !tx_full && !fl) exp_tx.push_back(d);
    @(posedge clk);
    #1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    auto_start = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, rd_auto && ($urandom_range(0, 2) == 0), 1'b0, 10'd0, 1'b0);
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (!(busy == 1'b0 && ctl_busy == 1'b0 && exp_tx.size() == 0) && k < budget) begin
      idleCycle();
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", busy, exp_tx.size());
    end
  endtask

  task automatic drainRx();
    int k = 0;
    while (rx_valid && k < 50) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 1'b0);
      k++;
    end
    checkOutput("rx_drained_valid", 32'(rx_valid), 32'd0);
    checkOutput("rx_drained_model", 32'(exp_rx.size()), 32'd0);
  endtask

  task automatic autoBurst(input logic [9:0] len);
    int n = (len == 10'd0) ? 1024 : int'(len);
    for (int i = 0; i < n; i++) exp_tx.push_back(8'hFF);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, len, 1'b0);
  endtask

  // Behavioural spictrl: random ack latency and transfer length, random or all-ones MISO.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ctl_txstart) begin
        int d = $urandom_range(0, 2);
        int h = $urandom_range(1, 4);
        int k;
        bit aborted = 1'b0;
        logic [7:0] rb = miso_ones ? 8'hFF : 8'($urandom);
        xfer_idx++;
        k = 0;
        while (k < d && !aborted) begin
          @(negedge clk);
          k++;
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          ctl_busy = 1'b1;
          k = 0;
          while (k < h && !aborted) begin
            @(negedge clk);
            k++;
            if (!rst_n) aborted = 1'b1;
          end
        end
        ctl_rxdata = rb;
        ctl_busy   = 1'b0;
        if (!aborted && xfer_idx != drop_idx) exp_rx.push_back(rb);
      end
    end
  end

  // Monitor: checks every issued byte and every RX dequeue against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ctl_txstart) begin
          txstart_cnt++;
          if (exp_tx.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL txstart_unexpected: got data %0h, expected no transfer", ctl_txdata);
          end else begin
            checkOutput("ctl_txdata", 32'(ctl_txdata), 32'(exp_tx.pop_front()));
          end
          last_tx = ctl_txdata;
        end
        if (ctl_busy) checkOutput("txdata_hold", 32'(ctl_txdata), 32'(last_tx));
        if (rd_en && rx_valid) begin
          if (exp_rx.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL rd_unexpected: got %0h, expected empty", rd_data);
          end else begin
            checkOutput("rd_data", 32'(rd_data), 32'(exp_rx.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_fail + 1);
    $finish;
  end

  initial begin
    int base;
    bit was_full;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_rd_data", 32'(rd_data), 32'h00);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_tx_full", 32'(tx_full), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_txstart", 32'(ctl_txstart), 32'd0);
    checkOutput("rst_txdata", 32'(ctl_txdata), 32'h00);
    @(posedge clk);
    #1;

    $display("[TB] two-byte write with MISO high");
    miso_ones = 1'b1;
    base = txstart_cnt;
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 10'd0, 1'b0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 10'd0, 1'b0);
    waitIdle(200);
    checkOutput("two_byte_starts", 32'(txstart_cnt - base), 32'd2);
    checkOutput("two_byte_busy", 32'(busy), 32'd0);
    drainRx();

    $display("[TB] random TX traffic with random reads");
    miso_ones = 1'b0;
    rd_auto   = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1 && !tx_full)
        applyStimulus(1'b1, 8'($urandom), $urandom_range(0, 2) == 0, 1'b0, 10'd0, 1'b0);
      else
        idleCycle();
    end
    waitIdle(2000);
    drainRx();

    $display("[TB] auto bursts with TX writes queued behind them");
    autoBurst(10'd3);
    applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b1, 10'd5, 1'b0);
    applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 10'd0, 1'b0);
    waitIdle(500);
    drainRx();
    autoBurst(10'($urandom_range(1, 12)));
    waitIdle(1000);
    drainRx();
    autoBurst(10'd0);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 10'd0, 1'b0);
    waitIdle(40000);
    drainRx();

    $display("[TB] RX full blocks issue; TX overflow");
    rd_auto = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 10'd0, 1'b0);
    waitIdle(300);
    checkOutput("rx_full_valid", 32'(rx_valid), 32'd1);
    base = txstart_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) checkOutput("tx_full_at4", 32'(tx_full), 32'd1);
      was_full = tx_full;
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 10'd0, 1'b0);
      if (i == 0) checkOutput("tx_not_full_at1", 32'(was_full), 32'd0);
    end
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    repeat (10) idleCycle();
    checkOutput("blocked_no_start", 32'(txstart_cnt - base), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 1'b0);
    repeat (2) idleCycle();
    checkOutput("issue_after_read", 32'(txstart_cnt - base), 32'd1);
    rd_auto = 1'b1;
    waitIdle(1000);
    drainRx();
    checkOutput("ovf_sticky", 32'(ovf), 32'd1);

    $display("[TB] flush during second byte of an auto burst");
    rd_auto = 1'b0;
    base = xfer_idx;
    autoBurst(10'd10);
    begin
      int k = 0;
      while (!(xfer_idx == base + 2 && ctl_busy) && k < 100) begin
        idleCycle();
        k++;
      end
      checkOutput("flush_reached_byte2", 32'(xfer_idx - base), 32'd2);
    end
    drop_idx = xfer_idx;
    exp_tx.delete();
    exp_rx.delete();
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 10'd0, 1'b1);
    base = txstart_cnt;
    repeat (15) idleCycle();
    checkOutput("flush_no_start", 32'(txstart_cnt - base), 32'd0);
    checkOutput("flush_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("flush_tx_full", 32'(tx_full), 32'd0);
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_ovf", 32'(ovf), 32'd0);

    $display("[TB] reset during a transfer");
    applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 10'd0, 1'b0);
    begin
      int k = 0;
      while (!ctl_busy && k < 50) begin
        idleCycle();
        k++;
      end
      checkOutput("reset_reached_busy", 32'(ctl_busy), 32'd1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_tx.delete();
    @(negedge clk);
    checkOutput("mid_rst_rd_data", 32'(rd_data), 32'h00);
    checkOutput("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("mid_rst_tx_full", 32'(tx_full), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ovf", 32'(ovf), 32'd0);
    checkOutput("mid_rst_txstart", 32'(ctl_txstart), 32'd0);
    checkOutput("mid_rst_txdata", 32'(ctl_txdata), 32'h00);
    @(posedge clk);
    #1;
    repeat (10) idleCycle();
    checkOutput("post_rst_no_push", 32'(rx_valid), 32'd0);
    checkOutput("post_rst_model_rx", 32'(exp_rx.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per TX FIFO and per RX FIFO (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port wr_data  input  8  byte to enqueue in TX FIFO.
REQ-005 SHALL have port wr_en  input  1  one-cycle enqueue strobe.
REQ-006 SHALL have port rd_en  input  1  one-cycle RX FIFO dequeue strobe.
REQ-007 SHALL have port rd_data  output  8  RX FIFO head byte (first-word-fall-through).
REQ-008 SHALL have port rx_valid  output  1  RX FIFO non-empty.
REQ-009 SHALL have port tx_full  output  1  TX FIFO full.
REQ-010 SHALL have port auto_len  input  10  number of 0xFF fill bytes for an auto burst; 0 means 1024.
REQ-011 SHALL have port auto_start  input  1  one-cycle strobe launching an auto burst.
REQ-012 SHALL have port flush  input  1  one-cycle strobe clearing FIFOs and aborting bursts.
REQ-013 SHALL have port busy  output  1  sequencer not idle, or TX FIFO non-empty.
REQ-014 SHALL have port ovf  output  1  sticky: write to full TX FIFO occurred; cleared by flush or reset.
REQ-015 SHALL have ports ctl_txdata (output 8), ctl_txstart (output 1), ctl_rxdata (input 8), ctl_busy (input 1), connecting to the byte-level spictrl txdata/txstart/rxdata/busy.

Function
REQ-016 SHALL use FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, STORE.
REQ-017 IDLE SHALL go to ISSUE when there is a byte source (auto count > 0, else TX FIFO non-empty) and the RX FIFO has at least one free slot.
REQ-018 ISSUE SHALL drive ctl_txstart high for exactly one cycle, with ctl_txdata = 0xFF in auto mode or the TX FIFO head otherwise, then go to WAIT_ACK.
REQ-019 ISSUE SHALL pop the TX FIFO head (non-auto mode) or decrement the auto count (auto mode) in the same cycle.
REQ-020 WAIT_ACK SHALL go to WAIT_DONE on ctl_busy=1.
REQ-021 WAIT_DONE SHALL go to STORE on ctl_busy=0.
REQ-022 STORE SHALL push ctl_rxdata into the RX FIFO and return to IDLE; minimum byte-to-byte gap SHALL therefore be 2 idle clk cycles after busy falls.
REQ-023 ctl_txdata SHALL be held stable from ISSUE until STORE.
REQ-024 While an auto burst is pending, the TX FIFO SHALL NOT be drained; TX writes SHALL still be accepted.
REQ-025 auto_start SHALL be ignored while the auto count is non-zero; otherwise the count SHALL load auto_len (0 loads 1024).
REQ-026 wr_en with tx_full=1 SHALL discard the byte and set ovf.
REQ-027 rd_en with rx_valid=0 SHALL be ignored.
REQ-028 Simultaneous push and pop on either FIFO SHALL both take effect, leaving the count unchanged.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; counts SHALL be log2(DEPTH)+1 bits wide.
REQ-030 flush SHALL, in the next cycle, empty both FIFOs, zero the auto count and clear ovf.
REQ-031 When flush occurs in WAIT_ACK or WAIT_DONE, the FSM SHALL finish the in-flight byte, discard its received data in STORE (no push), then return to IDLE.
REQ-032 When flush and wr_en coincide, flush SHALL win and the byte SHALL be dropped.

Reset
REQ-033 On rst_n=0 at a clk edge: FSM to IDLE; FIFOs empty; auto count 0; ovf=0; ctl_txstart=0; ctl_txdata=0x00.
REQ-034 Reset outputs after reset SHALL be: rd_data=0x00, rx_valid=0, tx_full=0, busy=0.
REQ-035 Reset mid-transfer SHALL abandon the transfer without a push; spictrl is reset by the same reset.

Structure
REQ-036 FSM state encoding and the 0xFF fill constant SHALL live in a shared package (spi_pkg).
REQ-037 Both FIFOs SHALL be instances of one sub-module, spi_fifo (parameter DEPTH, width 8, FWFT, count output).

Verification
REQ-038 Write 0x55, 0xA3 with spictrl miso=1 -> two ctl_txstart pulses with data 0x55 then 0xA3; RX holds 0xFF, 0xFF; busy falls after the second STORE.
REQ-039 auto_len=3, auto_start -> three 0xFF bytes issued, RX count 3; a TX byte written meanwhile is issued only after the third STORE.
REQ-040 DEPTH=4; fill RX with 4 bytes, queue 1 TX byte -> no ctl_txstart until rd_en, then issued within 2 cycles.
REQ-041 Write 5 bytes to an idle-blocked TX FIFO (RX full) -> tx_full after 4, fifth write dropped, ovf=1.
REQ-042 flush during WAIT_DONE of byte 2 of auto_len=10 -> no RX push for byte 2, no further ctl_txstart, FIFOs empty, ovf=0.
REQ-043 rst_n=0 for one cycle mid-WAIT_DONE -> all REQ-033/034 values next cycle, no RX push.
